// File: rtl/burst_resp_pkg.sv
// burst_resp_pkg: shared state encoding, burst bound and stall-LFSR constants for burst_mem_responder.
package burst_resp_pkg;
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_ADDR = 3'd1,
      RD_BEAT = 3'd2,
      WR_GAP  = 3'd3,
      WR_BEAT = 3'd4
   } state_t;
   localparam int DEF_MAX_BURST = 256;
   localparam logic [7:0] LFSR_SEED = 8'hA5;
   localparam logic [7:0] LFSR_TAPS = 8'hB8;
   function automatic logic [7:0] lfsr_next(input logic [7:0] s);
      return {s[6:0], ^(s & LFSR_TAPS)};
   endfunction
endpackage

// File: rtl/burst_resp_ram.sv
// burst_resp_ram: single-port 32-bit block RAM, one-cycle synchronous read with output enable, zero-filled.
module burst_resp_ram #(
  parameter int    AW        = 14,
  parameter string INIT_FILE = ""
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   q
);
  logic [31:0] mem [0:(1<<AW)-1];
  initial for (int i = 0; i < (1 << AW); i++) mem[i] = 32'h0;
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (en) q <= mem[addr];
  end
endmodule

// File: rtl/burst_mem_responder.sv
// burst_mem_responder: burst read/write responder over an internal block RAM.
// Define BURST_RESP_WAIT_EN to insert 0-3 pseudo-random stall cycles before every beat.
module burst_mem_responder
   import burst_resp_pkg::*;
#(
   parameter int    ADDR_WIDTH = 14,
   parameter int    MAX_BURST  = DEF_MAX_BURST,
   parameter string INIT_FILE  = ""
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        burst_en,
   input  logic [7:0]  burst_length,
   input  logic [31:0] a,
   input  logic [31:0] d,
   input  logic        we,
   input  logic        rd,
   output logic [31:0] spo,
   output logic        ready,
   output logic        busy
);
   state_t state, state_nx;
   logic [ADDR_WIDTH-1:0] ptr;
   logic [8:0] cnt;
   logic [31:0] q;
   logic go, beat, last, accept, unused;
   assign accept = state == IDLE && (we | rd);
   assign beat   = (state == RD_BEAT || state == WR_BEAT) && go;
   assign last   = cnt == 9'd1;
   assign ready  = beat;
   assign busy   = state != IDLE;
   assign spo    = (beat && state == RD_BEAT) ? q : 32'h0;
   assign unused = ^{a[31:ADDR_WIDTH+2], a[1:0]};
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = accept ? (we ? WR_GAP : RD_ADDR) : IDLE;
         RD_ADDR: state_nx = RD_BEAT;
         RD_BEAT: state_nx = (beat && last) ? IDLE : RD_BEAT;
         WR_GAP:  state_nx = WR_BEAT;
         WR_BEAT: state_nx = beat ? (last ? IDLE : WR_GAP) : WR_BEAT;
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         ptr   <= '0;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         if (accept) begin
            ptr <= a[ADDR_WIDTH+1:2];
            cnt <= burst_en ? (burst_length == 8'd0 ? 9'(MAX_BURST) : {1'b0, burst_length}) : 9'd1;
         end else if (state == RD_ADDR || beat) begin
            ptr <= ptr + 1'b1;
         end
         if (beat) cnt <= cnt - 1'b1;
      end
   end
`ifdef BURST_RESP_WAIT_EN
   logic [7:0] lfsr;
   logic [1:0] stall;
   logic enter;
   assign go    = stall == 2'd0;
   assign enter = (state_nx == RD_BEAT || state_nx == WR_BEAT) && (state != state_nx || beat);
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lfsr  <= LFSR_SEED;
         stall <= 2'd0;
      end else begin
         lfsr  <= lfsr_next(lfsr);
         stall <= enter ? lfsr[1:0] : (stall != 2'd0 ? stall - 2'd1 : stall);
      end
   end
`else
   assign go = 1'b1;
`endif
   // A stalled read freezes the RAM output register so the pending word is held.
   burst_resp_ram #(.AW(ADDR_WIDTH), .INIT_FILE(INIT_FILE)) u_ram (
      .clk   (clk),
      .en    (!(state == RD_BEAT && !go)),
      .we    (state == WR_BEAT && go),
      .addr  (ptr),
      .wdata (d),
      .q     (q)
   );
endmodule
